uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
UART transmit engine, the counterpart of the team's receiver FSM. It accepts one byte per handshake and serialises it onto tx_out as a frame: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1). Each bit is held for CLKS_PER_BIT clocks using an internal baud counter. It sits between the host-side byte source and the serial line feeding the receiver.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (legal range 2..65535; counter width is $clog2(CLKS_PER_BIT)).
PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
Clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
tx_start_in  input  1  request to send tx_data_in; sampled only in IDLE.
tx_data_in  input  8  byte to transmit; captured on the accepted start.
tx_out  output  1  serial line, registered, idle high.
tx_busy_out  output  1  high from the cycle after acceptance until frame end.
tx_done_out  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, tx_out=1, tx_busy_out=0, tx_done_out=0, baud counter=0, bit index=0, shift register=0. Reset mid-frame aborts immediately and the line goes high with no partial stop bit.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE: tx_out=1, busy=0. If tx_start_in=1 at edge N:
  - latch tx_data_in;
  - compute parity = ^tx_data_in ^ PARITY_ODD;
  - go to START.
  - At N+1: tx_out=0 and busy=1.
- Bit timing: a bit is presented for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1; the state or bit advances on terminal count, and the counter wraps to 0.
- START: hold 0 for one bit time, then go to DATA with bit index=0.
- DATA: tx_out = shift[0]; on each terminal count, shift right and increment the 3-bit index. After index 7 completes, go to PARITY. The index wrap 7->0 must not cause a ninth data bit.
- PARITY: hold the parity bit for one bit time, then go to STOP.
- STOP: hold 1 for one bit time. On its terminal count:
  - go to IDLE;
  - set tx_done_out=1 for exactly one cycle (the first IDLE cycle);
  - set busy=0 in that same cycle.
- Frame length: 11*CLKS_PER_BIT cycles from the first start-bit cycle to the first IDLE cycle.
- Handshake:
  - tx_start_in is ignored while busy; no queuing.
  - tx_data_in changes during a frame have no effect.
  - tx_start_in=1 in the same cycle as tx_done_out (IDLE) is accepted. The next start bit then begins the following cycle, giving back-to-back frames with one idle-high cycle between stop and start.
  - tx_start_in held high continuously sends repeated frames of the currently presented data.
- Unused/illegal state encodings recover to IDLE with tx_out=1.

Test Plan:
1. Reset behaviour, CLKS_PER_BIT=4: assert reset_n=0 for 3 cycles, release -> tx_out=1, busy=0, done=0. Pulse start with 0xA5 -> line over 44 cycles, 4 cycles per bit, is 0,1,0,1,0,0,1,0,1, parity 0, stop 1. busy=1 throughout; done pulses at cycle 45.
2. Even-parity check: 0x01 -> parity bit 1. 0xFF -> parity 0. 0x00 -> parity 0. Rerun with PARITY_ODD=1 -> 0x01 gives parity 0 and 0x00 gives parity 1.
3. Start while busy: accept 0x3C, pulse start with 0xC3 mid-frame -> 0x3C frame unaffected, no second frame, done pulses once.
4. Back-to-back: hold start=1 with data 0x55 -> consecutive frames each 44 cycles. Exactly one tx_out=1 IDLE cycle between each stop bit and the next start bit. done pulses once per frame.
5. Reset mid-frame: assert reset_n during data bit 3 of 0x81 -> tx_out=1 asynchronously, busy=0, no done pulse. A subsequent start of 0x81 produces a complete, correct frame.
6. Data stability: change tx_data_in every cycle after acceptance of 0x5A -> serialised bits still match 0x5A LSB first, parity 0.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmit engine: start bit, 8 data bits LSB first, parity bit, stop bit.
// Every bit is held for CLKS_PER_BIT clocks; all outputs are registered.
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       tx_start_in,
  input  logic [7:0] tx_data_in,
  output logic       tx_out,
  output logic       tx_busy_out,
  output logic       tx_done_out
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] baud_cnt, cnt_next;
  logic [2:0]    bit_idx, idx_next;
  logic [7:0]    shift, shift_next;
  logic          parity, par_next;
  logic          terminal;
  logic          tx_next, busy_next, done_next;

  assign terminal = (baud_cnt == LAST);

  // State register
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; unknown encodings fall back to IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tx_start_in)                   next_state = START;
      START:   if (terminal)                      next_state = DATA;
      DATA:    if (terminal && bit_idx == 3'd7)   next_state = PARITY;
      PARITY:  if (terminal)                      next_state = STOP;
      STOP:    if (terminal)                      next_state = IDLE;
      default:                                    next_state = IDLE;
    endcase
  end

  // Datapath next values: baud counter, bit index, shift register, parity
  always_comb begin
    cnt_next   = baud_cnt;
    idx_next   = bit_idx;
    shift_next = shift;
    par_next   = parity;
    case (state)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (tx_start_in) begin
          shift_next = tx_data_in;
          par_next   = (^tx_data_in) ^ ODD;
        end
      end
      START, PARITY, STOP: begin
        cnt_next = terminal ? '0 : baud_cnt + 1'b1;
        if (terminal) idx_next = '0;
      end
      DATA: begin
        cnt_next = terminal ? '0 : baud_cnt + 1'b1;
        if (terminal) begin
          shift_next = {1'b0, shift[7:1]};
          // index wraps 7->0 only as DATA is left, so no ninth bit is sent
          idx_next   = bit_idx + 3'd1;
        end
      end
      default: begin
        cnt_next = '0;
        idx_next = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
    end else begin
      baud_cnt <= cnt_next;
      bit_idx  <= idx_next;
      shift    <= shift_next;
      parity   <= par_next;
    end
  end

  // Output decode from the upcoming state so the registered outputs align with it
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (next_state != IDLE);
    done_next = (state == STOP) && (next_state == IDLE);
    case (next_state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_next;
      default: tx_next = 1'b1;
    endcase
  end

  // Output registers
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_out      <= 1'b1;
      tx_busy_out <= 1'b0;
      tx_done_out <= 1'b0;
    end else begin
      tx_out      <= tx_next;
      tx_busy_out <= busy_next;
      tx_done_out <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: instance 0 even parity, instance 1 odd parity,
// both with 4 clocks per bit. Frames are decoded from the line and scored.
module tb_uart_transmitter;

  logic       Clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start_w [2];
  logic [7:0] data_w  [2];
  logic       tx_w    [2];
  logic       busy_w  [2];
  logic       done_w  [2];

  logic [8:0] q0 [$];
  logic [8:0] q1 [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit b2b   = 1'b0;
  int last_done = -1;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) dut_even (
    .Clk(Clk), .reset_n(reset_n), .tx_start_in(start_w[0]), .tx_data_in(data_w[0]),
    .tx_out(tx_w[0]), .tx_busy_out(busy_w[0]), .tx_done_out(done_w[0])
  );

  uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) dut_odd (
    .Clk(Clk), .reset_n(reset_n), .tx_start_in(start_w[1]), .tx_data_in(data_w[1]),
    .tx_out(tx_w[1]), .tx_busy_out(busy_w[1]), .tx_done_out(done_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected entry: {parity, data}
  task automatic push(input int id, input logic [7:0] d, input logic p);
    if (id == 0) q0.push_back({p, d});
    else         q1.push_back({p, d});
  endtask

  task automatic send(input int id, input logic [7:0] d, input logic p);
    push(id, d, p);
    @(negedge Clk);
    data_w[id]  = d;
    start_w[id] = 1'b1;
    @(posedge Clk);
    #1 start_w[id] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Monitor: captures 44 line samples per frame, then checks the done cycle
  task automatic mon(input int id);
    logic [43:0] s;
    logic [10:0] got;
    logic [8:0]  e;
    bit ok_busy, ok_stab, aborted, have;
    forever begin
      @(negedge Clk);
      if (reset_n && busy_w[id]) begin
        if (id == 0 && b2b && last_done >= 0)
          chk("b2b_gap", cyc - last_done, 1);
        s = '0;
        ok_busy = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < 44; k++) begin
          if (k > 0) @(negedge Clk);
          if (!reset_n) begin
            aborted = 1'b1;
            break;
          end
          s[k] = tx_w[id];
          if (!busy_w[id] || done_w[id]) ok_busy = 1'b0;
        end
        if (!aborted) begin
          @(negedge Clk);
          chk("end_done_busy_tx", {29'd0, done_w[id], busy_w[id], tx_w[id]}, 32'b101);
          if (id == 0) last_done = cyc;
          ok_stab = 1'b1;
          for (int j = 0; j < 11; j++) begin
            got[j] = s[4*j];
            for (int m = 1; m < 4; m++)
              if (s[4*j+m] !== s[4*j]) ok_stab = 1'b0;
          end
          chk("bit_stable", {31'd0, ok_stab}, 1);
          chk("busy_during_frame", {31'd0, ok_busy}, 1);
          have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
          chk("frame_expected", {31'd0, have}, 1);
          if (have) begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("frame%0d", id), {21'd0, got}, {21'd0, 1'b1, e[8], e[7:0], 1'b0});
          end
        end
      end else begin
        chk("idle_no_done", {31'd0, done_w[id]}, 0);
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    start_w[0] = 1'b0; start_w[1] = 1'b0;
    data_w[0]  = '0;   data_w[1]  = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk) reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_tx", {31'd0, tx_w[0]}, 1);
    chk("rst_busy", {31'd0, busy_w[0]}, 0);
    chk("rst_done", {31'd0, done_w[0]}, 0);
    chk("rst_tx_odd", {31'd0, tx_w[1]}, 1);

    // 1: basic frame
    send(0, 8'hA5, 1'b0); idle(50);

    // 2: parity cases
    send(0, 8'h01, 1'b1); idle(50);
    send(0, 8'hFF, 1'b0); idle(50);
    send(0, 8'h00, 1'b0); idle(50);
    send(1, 8'h01, 1'b0); idle(50);
    send(1, 8'h00, 1'b1); idle(50);

    // 3: start while busy is ignored
    send(0, 8'h3C, 1'b0);
    idle(20);
    data_w[0] = 8'hC3; start_w[0] = 1'b1;
    @(negedge Clk) start_w[0] = 1'b0;
    idle(40);

    // 4: start held high -> back-to-back frames
    b2b = 1'b1;
    last_done = -1;
    repeat (3) push(0, 8'h55, 1'b0);
    @(negedge Clk);
    data_w[0] = 8'h55; start_w[0] = 1'b1;
    repeat (91) @(posedge Clk);
    #1 start_w[0] = 1'b0;
    idle(60);
    b2b = 1'b0;

    // 5: reset during data bit 3
    @(negedge Clk);
    data_w[0] = 8'h81; start_w[0] = 1'b1;
    @(posedge Clk);
    #1 start_w[0] = 1'b0;
    repeat (17) @(posedge Clk);
    #3 reset_n = 1'b0;
    #1;
    chk("abort_tx", {31'd0, tx_w[0]}, 1);
    chk("abort_busy", {31'd0, busy_w[0]}, 0);
    chk("abort_done", {31'd0, done_w[0]}, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) reset_n = 1'b1;
    idle(5);
    send(0, 8'h81, 1'b0); idle(50);

    // 6: data input churns during the frame
    push(0, 8'h5A, 1'b0);
    @(negedge Clk);
    data_w[0] = 8'h5A; start_w[0] = 1'b1;
    @(posedge Clk);
    #1 start_w[0] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      data_w[0] = 8'($urandom);
    end
    idle(5);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
